// File: rtl/comparitor_search_controller.sv
// Successive-approximation search controller for the Comparitor datapath.
// Optional one-hot flag checking is enabled by defining CMP_SEARCH_FLAG_CHECK_EN.
module comparitor_search_controller #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             G,
  input  logic             E,
  input  logic             L,
  output logic [WIDTH-1:0] GuessOut,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Steps
);

  localparam int unsigned RW = WIDTH + 1;
  localparam logic [WIDTH-1:0] MaxVal = '1;

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

  state_e          r_state, w_state_nxt;
  logic [RW-1:0]   r_low, r_high, w_low_nxt, w_high_nxt, w_sum;
  logic [RW-1:0]   w_guess_ext, w_guess_inc, w_guess_dec;
  logic [WIDTH-1:0] r_guess, w_guess_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [WIDTH-1:0] r_steps, w_steps_nxt, w_steps_inc;
  logic            r_error, w_error_nxt;
  logic            w_flag_bad;

  assign w_guess_ext = {1'b0, r_guess};
  assign w_guess_inc = w_guess_ext + RW'(1);
  assign w_guess_dec = w_guess_ext - RW'(1);
  assign w_steps_inc = (r_steps == MaxVal) ? r_steps : r_steps + WIDTH'(1);

`ifdef CMP_SEARCH_FLAG_CHECK_EN
  // Odd parity but not all three set means exactly one flag is high.
  assign w_flag_bad = !((G ^ E ^ L) && !(G && E && L));
`else
  assign w_flag_bad = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state  <= StIdle;
      r_low    <= '0;
      r_high   <= '0;
      r_guess  <= '0;
      r_result <= '0;
      r_steps  <= '0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_low    <= w_low_nxt;
      r_high   <= w_high_nxt;
      r_guess  <= w_guess_nxt;
      r_result <= w_result_nxt;
      r_steps  <= w_steps_nxt;
      r_error  <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_low_nxt    = r_low;
    w_high_nxt   = r_high;
    w_guess_nxt  = r_guess;
    w_result_nxt = r_result;
    w_steps_nxt  = r_steps;
    w_error_nxt  = r_error;
    w_sum        = '0;
    case (r_state)
      StIdle: begin
        if (Start) begin
          w_low_nxt    = '0;
          w_high_nxt   = {1'b0, MaxVal};
          w_guess_nxt  = MaxVal >> 1;
          w_result_nxt = '0;
          w_steps_nxt  = '0;
          w_error_nxt  = 1'b0;
          w_state_nxt  = StSearch;
        end
      end
      StSearch: begin
        w_steps_nxt = w_steps_inc;
        if (w_flag_bad) begin
          w_error_nxt = 1'b1;
          w_state_nxt = StDone;
        end else if (E) begin
          w_result_nxt = r_guess;
          w_state_nxt  = StDone;
        end else if (G || L) begin
          if (G) w_low_nxt = w_guess_inc;
          else   w_high_nxt = w_guess_dec;
          w_sum       = w_low_nxt + w_high_nxt;
          w_guess_nxt = WIDTH'(w_sum >> 1);
          // Compare against the pre-decrement guess so High = 0 - 1 never wraps.
          if (G ? (w_guess_inc > r_high) : (r_low >= w_guess_ext)) begin
            w_error_nxt = 1'b1;
            w_state_nxt = StDone;
          end
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    Busy = (r_state == StSearch);
    Done = (r_state == StDone);
  end

  assign GuessOut = r_guess;
  assign Error    = r_error;
  assign Result   = r_result;
  assign Steps    = r_steps;

endmodule

// File: tb/tb_comparitor_search_controller.sv
// Randomized self-checking bench for comparitor_search_controller against an integer
// binary-search model. Honors CMP_SEARCH_FLAG_CHECK_EN in the model.
module tb_comparitor_search_controller;

  localparam int W = 4;
  localparam int MaxV = (1 << W) - 1;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Start = 1'b0;
  logic         G = 1'b0, E = 1'b0, L = 1'b0;
  logic [W-1:0] GuessOut, Result, Steps;
  logic         Busy, Done, Error;

  int n_checks = 0;
  int n_fail = 0;
  int q_guess[$];

  comparitor_search_controller #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .G        (G),
    .E        (E),
    .L        (L),
    .GuessOut (GuessOut),
    .Busy     (Busy),
    .Done     (Done),
    .Error    (Error),
    .Result   (Result),
    .Steps    (Steps)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Comparator behaviour: 0 = honest, 1 = always L, 2 = G and L together on compare 0.
  function automatic logic [2:0] cmp_flags(input int mode, input int refv, input int g,
                                           input int idx);
    logic [2:0] f;
    f = {refv > g, refv == g, refv < g};
    if (mode == 1) f = 3'b001;
    if (mode == 2 && idx == 0) f = 3'b101;
    return f;
  endfunction

  task automatic model_search(input int refv, input int mode, output int res, output int steps,
                              output bit err);
    int lo, hi, g;
    logic [2:0] f;
    q_guess.delete();
    lo = 0; hi = MaxV; res = 0; steps = 0; err = 1'b0;
    for (int i = 0; i < 64; i++) begin
      g = (lo + hi) / 2;
      q_guess.push_back(g);
      if (steps < MaxV) steps++;
      f = cmp_flags(mode, refv, g, i);
`ifdef CMP_SEARCH_FLAG_CHECK_EN
      if (!(f == 3'b100 || f == 3'b010 || f == 3'b001)) begin
        err = 1'b1;
        break;
      end
`endif
      if (f[1]) begin
        res = g;
        break;
      end else if (f[2]) lo = g + 1;
      else if (f[0]) hi = g - 1;
      if (lo > hi) begin
        err = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_search(input int refv, input int mode, input string tag);
    int res, steps, n;
    bit err;
    model_search(refv, mode, res, steps, err);
    n = q_guess.size();
    @(negedge Clk) Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    for (int i = 0; i < n; i++) begin
      {G, E, L} = cmp_flags(mode, refv, int'(GuessOut), i);
      check($sformatf("%s guess%0d", tag, i), int'(GuessOut), q_guess[i]);
      check($sformatf("%s busy%0d", tag, i), int'(Busy), 1);
      check($sformatf("%s nodone%0d", tag, i), int'(Done), 0);
      @(posedge Clk); #1;
    end
    {G, E, L} = 3'b000;
    check({tag, " done"}, int'(Done), 1);
    check({tag, " busy_off"}, int'(Busy), 0);
    check({tag, " error"}, int'(Error), int'(err));
    check({tag, " result"}, int'(Result), res);
    check({tag, " steps"}, int'(Steps), steps);
    @(posedge Clk); #1;
    check({tag, " done_pulse"}, int'(Done), 0);
    check({tag, " idle"}, int'(Busy), 0);
    check({tag, " error_hold"}, int'(Error), int'(err));
    check({tag, " result_hold"}, int'(Result), res);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " guess"}, int'(GuessOut), 0);
    check({tag, " busy"}, int'(Busy), 0);
    check({tag, " done"}, int'(Done), 0);
    check({tag, " error"}, int'(Error), 0);
    check({tag, " result"}, int'(Result), 0);
    check({tag, " steps"}, int'(Steps), 0);
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1 check_zero("reset");
    Reset_n = 1'b1;

    run_search(7, 0, "ref7");
    run_search(0, 0, "ref0");
    run_search(15, 0, "ref15");
    run_search(9, 1, "allL");
    run_search(11, 2, "gl_first");

    // Reset during the third search cycle aborts without Done.
    @(negedge Clk) Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      {G, E, L} = cmp_flags(0, 15, int'(GuessOut), i);
      if (i == 2) Reset_n = 1'b0;
      @(posedge Clk); #1;
    end
    {G, E, L} = 3'b000;
    check_zero("midreset");
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    check("midreset nodone", int'(Done), 0);
    run_search(15, 0, "after_reset");

    // Start held high: ignored in DONE, relaunches from the following IDLE cycle.
    @(negedge Clk) Start = 1'b1;
    @(posedge Clk); #1;
    {G, E, L} = cmp_flags(0, 7, int'(GuessOut), 0);
    @(posedge Clk); #1;
    check("held done", int'(Done), 1);
    @(posedge Clk); #1;
    check("held idle", int'(Busy), 0);
    @(posedge Clk); #1;
    Start = 1'b0;
    check("held relaunch", int'(Busy), 1);
    check("held guess", int'(GuessOut), 7);
    check("held steps_clr", int'(Steps), 0);
    @(posedge Clk); #1;
    {G, E, L} = 3'b000;
    check("held done2", int'(Done), 1);
    @(posedge Clk); #1;

    for (int t = 0; t < 24; t++) begin
      run_search(int'($urandom_range(0, MaxV)), 0, $sformatf("rnd%0d", t));
      repeat ($urandom_range(0, 2)) @(posedge Clk);
      #1;
    end
    for (int t = 0; t < 4; t++) begin
      run_search(int'($urandom_range(0, MaxV)), 2, $sformatf("rndgl%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/comparitor_search_controller.md
# comparitor_search_controller

Sequencing controller for the 4-bit `Comparitor` datapath. It finds an unknown reference value by successive approximation (binary search). It drives `ComparisonInput` with a guess each cycle and reads back the `G`/`E`/`L` flags until `E` asserts, then reports the found value and the number of comparisons used. It sits between the lab top level (switches/buttons, display) and a `Comparitor` instance whose `ComparisonReference` is wired to the hidden value.

## Interface
Parameters:
- `WIDTH`, 4, bit width of the compared values; the search space is 0 .. 2^WIDTH-1.

Ports:
- `Clk`  in  1  single system clock; all state updates on rising edge.
- `Reset_n`  in  1  synchronous, active-low reset, sampled on rising edge of `Clk`.
- `Start`  in  1  request a new search; sampled only in IDLE.
- `G`  in  1  from comparator: reference > `GuessOut`.
- `E`  in  1  from comparator: reference == `GuessOut`.
- `L`  in  1  from comparator: reference < `GuessOut`.
- `GuessOut`  out  WIDTH  drives comparator `ComparisonInput`; registered.
- `Busy`  out  1  high while in SEARCH.
- `Done`  out  1  one-cycle pulse when a search ends (found or error).
- `Error`  out  1  high with `Done` if the search failed; held until next Start.
- `Result`  out  WIDTH  found value; held until next accepted Start.
- `Steps`  out  WIDTH  comparisons consumed by the last search; held until next accepted Start.

## Operation
- States: IDLE, SEARCH, DONE.
- **IDLE**
  - On `Start`=1: Low=0, High=2^WIDTH-1, `GuessOut`=(Low+High)>>1 (7 for WIDTH=4).
  - Also clear `Result`, `Steps` and `Error`, then go to SEARCH.
- **SEARCH**: each cycle, evaluate the flags produced combinationally by the current `GuessOut`, and increment `Steps`.
  - `E`: `Result`=`GuessOut`, go to DONE.
  - `G`: Low=`GuessOut`+1.
  - `L`: High=`GuessOut`-1.
  - In both the `G` and `L` cases, load the next `GuessOut`=(Low'+High')>>1.
  - If the updated Low > High, set `Error` and go to DONE. This covers an inconsistent comparator.
- **DONE**: `Done`=1 for exactly one cycle, then go to IDLE.
- Width rules:
  - Low, High and the sum are held at WIDTH+1 bits.
  - High = 0 - 1 must not wrap; it produces Low > High and therefore Error.
  - `Steps` saturates at 2^WIDTH-1.
- Flag priority without checking (see Configuration): E > G > L. With no flag set, the guess holds and `Steps` still increments.
- `Start` while in SEARCH or DONE is ignored. `Start` held high re-launches a search in the cycle after DONE.

## Timing
- Reset (`Reset_n`=0 at an edge) → IDLE, with `GuessOut`=0, `Busy`=0, `Done`=0, `Error`=0, `Result`=0, `Steps`=0.
- Reset mid-SEARCH aborts the search with the same values; no `Done` is produced.
- `Start` sampled at edge k → `Busy`=1 and the first guess valid from edge k+1.
- Compare n resolves at edge k+n; `Done` is high in cycle k+n+1, then IDLE.
- Maximum of WIDTH+1 compares (5 for WIDTH=4), so total latency from Start to Done is ≤ WIDTH+2 cycles.
- The comparator is combinational; its flags must settle within one cycle of a `GuessOut` change.

## Configuration
- `CMP_SEARCH_FLAG_CHECK_EN` defined: in SEARCH, any flag pattern other than exactly one-hot (`G`,`E`,`L`) sets `Error`, leaves `Steps` incremented, and goes to DONE.
- Undefined: no one-hot check; the E > G > L priority applies, and an all-zero flag pattern stalls the guess.

## Test plan
- Reference 7, Start pulse → single guess 7, `Done` at cycle k+2, `Result`=7, `Steps`=1, `Error`=0.
- Reference 0 → guesses 7, 3, 1, 0; `Result`=0, `Steps`=4, no wrap on High.
- Reference 15 → guesses 7, 11, 13, 14, 15; `Result`=15, `Steps`=5, `Done` at k+6.
- Faulty comparator model that always returns `L` → guesses 7, 3, 1, 0, then Low > High; `Error`=1, `Done` pulses, `Steps`=4.
- `Reset_n`=0 at the third SEARCH cycle (reference 15) → next cycle all outputs 0, state IDLE, no `Done`; a new Start completes normally.
- With `CMP_SEARCH_FLAG_CHECK_EN` set, force `G`=`L`=1 on the first compare → `Error`=1, `Steps`=1, `Done` one cycle later. Without the macro, the same stimulus treats the compare as `G` and moves the next guess to 11.
